// File: rtl/ntt64_bram_sched.sv
// Sequencer for an in-place 64-point radix-2 DIF NTT on one two-port RAM.
// While idle the RAM is passed through to the host port. Results end up in bit-reversed order.
module ntt64_bram_sched #(
    parameter int BF_LAT = 3,
    parameter int W      = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         lat_err,
    input  logic         host_wr_en,
    input  logic [5:0]   host_addr,
    input  logic [W-1:0] host_din,
    output logic [W-1:0] host_dout,
    output logic         mem_wr_en,
    output logic [5:0]   mem_wr_addr,
    output logic [5:0]   mem_rd_addr,
    output logic [W-1:0] mem_wr_din,
    input  logic [W-1:0] mem_wr_dout,
    input  logic [W-1:0] mem_rd_dout,
    output logic         bf_in_valid,
    output logic [W-1:0] bf_a,
    output logic [W-1:0] bf_b,
    output logic [4:0]   bf_tw_idx,
    output logic [2:0]   bf_stage,
    input  logic         bf_out_valid,
    input  logic [W-1:0] bf_x,
    input  logic [W-1:0] bf_y
);
    localparam int L = BF_LAT / 3;
    localparam logic [7:0] LAT_SLOTS = 8'(L);
    localparam logic [7:0] LAST_SLOT = 8'(31 + L);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    // half-1 for stage s, where half = 32 >> s
    function automatic logic [4:0] half_mask(input logic [2:0] s);
        return 5'd31 >> s;
    endfunction

    function automatic logic [5:0] addr_a(input logic [2:0] s, input logic [4:0] c);
        logic [4:0] m;
        m = half_mask(s);
        return {c & ~m, 1'b0} | {1'b0, c & m};
    endfunction

    function automatic logic [5:0] addr_b(input logic [2:0] s, input logic [4:0] c);
        return addr_a(s, c) | ({1'b0, half_mask(s)} + 6'd1);
    endfunction

    function automatic logic [4:0] twiddle(input logic [2:0] s, input logic [4:0] c);
        return (c & half_mask(s)) << s;
    endfunction

    state_t       state_q, state_d;
    logic [1:0]   ph_q, ph_d;
    logic [7:0]   slot_q, slot_d;
    logic [2:0]   stage_q, stage_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         lat_err_q, lat_err_d;
    logic         bfv_q, bfv_d;
    logic         wa_q, wa_d;
    logic         wb_q, wb_d;
    logic [5:0]   wr_addr_q, wr_addr_d;
    logic [5:0]   rd_addr_q, rd_addr_d;
    logic [4:0]   tw_q, tw_d;
    logic [2:0]   bf_stage_q, bf_stage_d;
    logic [W-1:0] y_q, y_d;
    logic [11:0]  pipe_q [0:L];
    logic [11:0]  pipe_d [0:L];
    logic         rd_slot_s;
    logic         rd_issue_s;

    // Next-state sequencing and next-cycle schedule outputs
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        slot_d  = slot_q;
        stage_d = stage_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    ph_d    = 2'd0;
                    slot_d  = 8'd0;
                    stage_d = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN, DRAIN: begin
                if (state_q == RUN && ph_q == 2'd0 && slot_q == 8'd31) begin
                    state_d = DRAIN;
                end else begin
                    state_d = state_q;
                end
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d = 2'd0;
                    if (slot_q != LAST_SLOT) begin
                        slot_d = slot_q + 8'd1;
                    end else begin
                        slot_d = 8'd0;
                        if (stage_q == 3'd5) begin
                            state_d = DONE;
                            stage_d = 3'd0;
                        end else begin
                            state_d = RUN;
                            stage_d = stage_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d == RUN) || (state_d == DRAIN);
        done_d     = busy_q && (state_d == DONE);
        rd_slot_s  = busy_d && (slot_d < 8'd32);
        rd_issue_s = rd_slot_s && (ph_d == 2'd0);
        bfv_d      = rd_slot_s && (ph_d == 2'd1);
        wa_d       = busy_d && (ph_d == 2'd1) && (slot_d >= LAT_SLOTS);
        wb_d       = busy_d && (ph_d == 2'd2) && (slot_d >= LAT_SLOTS);

        // the pair read in slot k reaches the tail of the line at slot k+L
        pipe_d = pipe_q;
        if (busy_d && ph_d == 2'd0) begin
            pipe_d[0] = {addr_a(stage_d, slot_d[4:0]), addr_b(stage_d, slot_d[4:0])};
            for (int i = 1; i <= L; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end else begin
            pipe_d = pipe_q;
        end

        if (rd_issue_s) begin
            wr_addr_d = addr_a(stage_d, slot_d[4:0]);
            rd_addr_d = addr_b(stage_d, slot_d[4:0]);
        end else if (wa_d) begin
            wr_addr_d = pipe_d[L][11:6];
            rd_addr_d = rd_addr_q;
        end else if (wb_d) begin
            wr_addr_d = pipe_d[L][5:0];
            rd_addr_d = rd_addr_q;
        end else begin
            wr_addr_d = wr_addr_q;
            rd_addr_d = rd_addr_q;
        end

        if (bfv_d) begin
            tw_d       = twiddle(stage_d, slot_d[4:0]);
            bf_stage_d = stage_d;
        end else begin
            tw_d       = tw_q;
            bf_stage_d = bf_stage_q;
        end

        if (busy_q && wa_q) begin
            y_d = bf_y;
        end else begin
            y_d = y_q;
        end

        if ((state_q == IDLE || state_q == DONE) && start) begin
            lat_err_d = 1'b0;
        end else if (busy_q && (bf_out_valid != wa_q)) begin
            lat_err_d = 1'b1;
        end else begin
            lat_err_d = lat_err_q;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ph_q       <= 2'd0;
            slot_q     <= 8'd0;
            stage_q    <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lat_err_q  <= 1'b0;
            bfv_q      <= 1'b0;
            wa_q       <= 1'b0;
            wb_q       <= 1'b0;
            wr_addr_q  <= 6'd0;
            rd_addr_q  <= 6'd0;
            tw_q       <= 5'd0;
            bf_stage_q <= 3'd0;
            y_q        <= '0;
            for (int i = 0; i <= L; i++) begin
                pipe_q[i] <= 12'd0;
            end
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            slot_q     <= slot_d;
            stage_q    <= stage_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lat_err_q  <= lat_err_d;
            bfv_q      <= bfv_d;
            wa_q       <= wa_d;
            wb_q       <= wb_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tw_q       <= tw_d;
            bf_stage_q <= bf_stage_d;
            y_q        <= y_d;
            pipe_q     <= pipe_d;
        end
    end

    // RAM ports belong to the host whenever no transform is running
    assign mem_wr_en   = busy_q ? (wa_q | wb_q) : host_wr_en;
    assign mem_wr_addr = busy_q ? wr_addr_q : host_addr;
    assign mem_rd_addr = busy_q ? rd_addr_q : host_addr;
    assign mem_wr_din  = busy_q ? (wa_q ? bf_x : y_q) : host_din;
    assign host_dout   = mem_rd_dout;
    assign bf_a        = mem_wr_dout;
    assign bf_b        = mem_rd_dout;
    assign busy        = busy_q;
    assign done        = done_q;
    assign lat_err     = lat_err_q;
    assign bf_in_valid = bfv_q;
    assign bf_tw_idx   = tw_q;
    assign bf_stage    = bf_stage_q;
endmodule

// File: tb/tb_ntt64_bram_sched.sv
// Bench: two sequencers (butterfly latency 3 and 6) sharing host stimulus, each with its own
// RAM and increment butterfly; a per-cycle schedule model plus directed literal checks.
module tb_ntt64_bram_sched;
    localparam int W    = 18;
    localparam int LAT0 = 3;
    localparam int LAT1 = 6;
    localparam int PIN_T  [5] = '{0, 147, 102, 495, 588};
    localparam int PIN_A  [5] = '{0, 32, 1, 0, 62};
    localparam int PIN_B  [5] = '{32, 48, 17, 1, 63};
    localparam int PIN_TW [5] = '{0, 0, 2, 0, 0};
    localparam int PIN_ST [5] = '{0, 1, 1, 5, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, host_wr_en;
    logic [5:0]   host_addr;
    logic [W-1:0] host_din;
    logic [1:0]   kill_arm;

    wire  [1:0]   busy, done, lat_err, mem_wr_en, bf_in_valid, bf_out_valid;
    wire  [W-1:0] host_dout [2];
    wire  [W-1:0] mem_wr_din [2];
    wire  [W-1:0] mem_wr_dout [2];
    wire  [W-1:0] mem_rd_dout [2];
    wire  [W-1:0] bf_a [2];
    wire  [W-1:0] bf_b [2];
    wire  [W-1:0] bf_x [2];
    wire  [W-1:0] bf_y [2];
    wire  [5:0]   mem_wr_addr [2];
    wire  [5:0]   mem_rd_addr [2];
    wire  [4:0]   bf_tw_idx [2];
    wire  [2:0]   bf_stage [2];

    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        logic [W-1:0]   ram [64];
        logic [5:0]     wa_q, ra_q;
        logic [LAT-1:0] pv;
        logic [W-1:0]   px [LAT];
        logic [W-1:0]   py [LAT];
        logic           killed;

        ntt64_bram_sched #(.BF_LAT(LAT), .W(W)) u_dut (
            .clk(clk), .rst(rst), .start(start),
            .busy(busy[g]), .done(done[g]), .lat_err(lat_err[g]),
            .host_wr_en(host_wr_en), .host_addr(host_addr), .host_din(host_din),
            .host_dout(host_dout[g]),
            .mem_wr_en(mem_wr_en[g]), .mem_wr_addr(mem_wr_addr[g]), .mem_rd_addr(mem_rd_addr[g]),
            .mem_wr_din(mem_wr_din[g]), .mem_wr_dout(mem_wr_dout[g]), .mem_rd_dout(mem_rd_dout[g]),
            .bf_in_valid(bf_in_valid[g]), .bf_a(bf_a[g]), .bf_b(bf_b[g]),
            .bf_tw_idx(bf_tw_idx[g]), .bf_stage(bf_stage[g]),
            .bf_out_valid(bf_out_valid[g]), .bf_x(bf_x[g]), .bf_y(bf_y[g])
        );

        assign mem_wr_dout[g]  = ram[wa_q];
        assign mem_rd_dout[g]  = ram[ra_q];
        assign bf_out_valid[g] = pv[LAT-1];
        assign bf_x[g]         = px[LAT-1];
        assign bf_y[g]         = py[LAT-1];

        // RAM with registered addresses, and an increment butterfly of fixed latency
        always @(posedge clk) begin
            if (mem_wr_en[g]) ram[mem_wr_addr[g]] <= mem_wr_din[g];
            wa_q  <= mem_wr_addr[g];
            ra_q  <= mem_rd_addr[g];
            px[0] <= bf_a[g] + 18'd1;
            py[0] <= bf_b[g] + 18'd1;
            for (int j = 1; j < LAT; j++) begin
                px[j] <= px[j-1];
                py[j] <= py[j-1];
            end
            if (rst) begin
                pv     <= '0;
                killed <= 1'b0;
            end else begin
                pv <= {pv[LAT-2:0], bf_in_valid[g] & ~(kill_arm[g] & ~killed)};
                if (!kill_arm[g]) killed <= 1'b0;
                else if (bf_in_valid[g]) killed <= 1'b1;
            end
        end
    end

    bit running [2] = '{1'b0, 1'b0};
    bit armed [2]   = '{1'b0, 1'b0};
    int run_t [2]   = '{0, 0};
    int done_t [2]  = '{-1, -1};
    int run_no = 0;
    int pin_wr [5], pin_rd [5], pin_tw [5], pin_st [5];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int bfly_a(input int s, input int c);
        int half;
        half = 32 >> s;
        return (c / half) * 2 * half + (c % half);
    endfunction

    task automatic check_cycle(input int i, input int t);
        int len, nb, s, u, p, k, half, ea, etw, ewa;
        bit e_busy, e_done, e_bfv, e_we, e_rd, ok;
        len = 96 + lat_of(i);
        nb = lat_of(i) / 3;
        e_busy = (t < 6 * len);
        e_done = (t == 6 * len);
        {e_bfv, e_we, e_rd} = 3'b000;
        {s, p, k, half, ea, etw, ewa} = '0;
        if (e_busy) begin
            s = t / len; u = t % len; p = u % 3; k = u / 3; half = 32 >> s;
            e_rd  = (k < 32) && (p == 0);
            e_bfv = (k < 32) && (p == 1);
            e_we  = (k >= nb) && (p != 0);
            if (k < 32) begin
                ea  = bfly_a(s, k);
                etw = (k % half) << s;
            end
            if (e_we) ewa = bfly_a(s, k - nb) + ((p == 2) ? half : 0);
        end
        ok = (busy[i] == e_busy) && (done[i] == e_done) && (bf_in_valid[i] == e_bfv) && (mem_wr_en[i] == e_we);
        if (e_rd) ok = ok && (int'(mem_wr_addr[i]) == ea) && (int'(mem_rd_addr[i]) == ea + half);
        if (e_bfv) ok = ok && (int'(bf_stage[i]) == s) && (int'(bf_tw_idx[i]) == etw);
        if (e_we) ok = ok && (int'(mem_wr_addr[i]) == ewa);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sched inst=%0d t=%0d got busy=%0b done=%0b v=%0b we=%0b wa=%0d ra=%0d st=%0d tw=%0d required busy=%0b done=%0b v=%0b we=%0b a=%0d wa=%0d st=%0d tw=%0d",
                     i, t, busy[i], done[i], bf_in_valid[i], mem_wr_en[i], mem_wr_addr[i], mem_rd_addr[i],
                     bf_stage[i], bf_tw_idx[i], e_busy, e_done, e_bfv, e_we, ea, ewa, s, etw);
        end
        if (done[i] && done_t[i] < 0) done_t[i] = t;
        if (i == 0 && run_no == 1) begin
            for (int j = 0; j < 5; j++) begin
                if (t == PIN_T[j]) begin
                    pin_wr[j] = int'(mem_wr_addr[0]);
                    pin_rd[j] = int'(mem_rd_addr[0]);
                end
                if (t == PIN_T[j] + 1) begin
                    pin_tw[j] = int'(bf_tw_idx[0]);
                    pin_st[j] = int'(bf_stage[0]);
                end
            end
        end
    endtask

    // Per-cycle comparison against the schedule model, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                running[i] = 1'b0;
                armed[i]   = 1'b0;
            end else begin
                if (armed[i]) begin
                    armed[i]   = 1'b0;
                    running[i] = 1'b1;
                    run_t[i]   = 0;
                    done_t[i]  = -1;
                    if (i == 0) run_no++;
                end
                if (running[i]) begin
                    check_cycle(i, run_t[i]);
                    if (run_t[i] == 6 * (96 + lat_of(i))) running[i] = 1'b0;
                    else run_t[i]++;
                end
                if (!running[i] && start && !busy[i]) armed[i] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_runs();
        int n;
        n = 0;
        while ((armed[0] || armed[1] || running[0] || running[1]) && n < 2000) begin
            tick();
            n++;
        end
        chk("run_timeout", (n < 2000) ? 1 : 0, 1);
    endtask

    task automatic host_load();
        for (int a = 0; a < 64; a++) begin
            host_wr_en = 1'b1; host_addr = 6'(a); host_din = 18'(a);
            tick();
        end
        host_wr_en = 1'b0;
    endtask

    task automatic host_verify(input string name, input int offs);
        for (int a = 0; a < 64; a++) begin
            host_addr = 6'(a);
            tick();
            for (int i = 0; i < 2; i++) begin
                if (int'(host_dout[i]) != a + offs) begin
                    chk(name, int'(host_dout[i]), a + offs);
                end else begin
                    checks++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; host_wr_en = 1'b0; host_addr = 6'd0; host_din = '0; kill_arm = 2'b00;
        #3 rst = 1'b1;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_lat_err", int'(lat_err), 0);
        chk("reset_mem_wr_en", int'(mem_wr_en), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        host_load();
        host_wr_en = 1'b1; host_addr = 6'd5; host_din = 18'h2ABCD;
        tick();
        host_wr_en = 1'b0; host_addr = 6'd0;
        tick();
        host_addr = 6'd5;
        tick();
        chk("host_rb0", int'(host_dout[0]), 18'h2ABCD);
        chk("host_rb1", int'(host_dout[1]), 18'h2ABCD);
        host_wr_en = 1'b1; host_din = 18'd5;
        tick();
        host_wr_en = 1'b0;

        // run 1: host writes while busy must not reach the RAM
        do_start();
        repeat (10) tick();
        host_wr_en = 1'b1; host_addr = 6'd5; host_din = 18'h3FFFF;
        repeat (5) tick();
        host_wr_en = 1'b0;
        wait_runs();
        chk("done_t_lat3", done_t[0], 594);
        chk("done_t_lat6", done_t[1], 612);
        chk("lat_err_run1", int'(lat_err), 0);
        for (int j = 0; j < 5; j++) begin
            chk("pin_a", pin_wr[j], PIN_A[j]);
            chk("pin_b", pin_rd[j], PIN_B[j]);
            chk("pin_tw", pin_tw[j], PIN_TW[j]);
            chk("pin_stage", pin_st[j], PIN_ST[j]);
        end
        host_verify("ram_run1", 6);

        // run 2: one missing bf_out_valid on the latency-3 instance
        kill_arm = 2'b01;
        do_start();
        wait_runs();
        kill_arm = 2'b00;
        chk("lat_err_set", int'(lat_err[0]), 1);
        chk("lat_err_clean", int'(lat_err[1]), 0);
        host_verify("ram_run2", 12);
        repeat (5) tick();
        chk("lat_err_sticky", int'(lat_err[0]), 1);

        // run 3: aborted by reset mid-run
        do_start();
        chk("lat_err_cleared", int'(lat_err[0]), 0);
        repeat (199) tick();
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        tick();
        rst = 1'b0;
        tick();

        host_load();
        host_addr = 6'd7;
        tick();
        chk("post_abort_rb", int'(host_dout[0]), 7);

        // run 4: normal completion after abort
        do_start();
        wait_runs();
        chk("done_t4_lat3", done_t[0], 594);
        chk("done_t4_lat6", done_t[1], 612);
        chk("lat_err_run4", int'(lat_err), 0);
        host_verify("ram_run4", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ntt64_bram_sched.md
Name: ntt64_bram_sched

Overview:
Sequencer for an in-place 64-point radix-2 DIF NTT on one 18x64 RAM with 1 write/read-back port and 1 read port, both with registered addresses and combinational data out. When idle, the RAM ports pass through to a host port for load and unload. When running, the block owns the RAM: it issues butterfly operand reads, drives twiddle and stage indices to an external fixed-latency butterfly, and writes results back. Output data is left in bit-reversed order.

Parameters:
BF_LAT, 3, butterfly latency in cycles from bf_in_valid to bf_out_valid; must be a positive multiple of 3.
W, 18, data width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request, sampled only in IDLE/DONE
busy  out  1  high while transform runs
done  out  1  one-cycle pulse at completion
lat_err  out  1  sticky flag: bf_out_valid mismatch
host_wr_en  in  1  host write (honoured only when not busy)
host_addr  in  6  host address (write and read)
host_din  in  W  host write data
host_dout  out  W  = mem_rd_dout
mem_wr_en  out  1  RAM write enable
mem_wr_addr  out  6  RAM write/read-back address
mem_rd_addr  out  6  RAM read address
mem_wr_din  out  W  RAM write data
mem_wr_dout  in  W  RAM read-back data
mem_rd_dout  in  W  RAM read data
bf_in_valid  out  1  operands valid
bf_a  out  W  = mem_wr_dout (operand at a)
bf_b  out  W  = mem_rd_dout (operand at b)
bf_tw_idx  out  5  twiddle index
bf_stage  out  3  stage 0..5
bf_out_valid  in  1  results valid
bf_x  in  W  result written to a
bf_y  in  W  result written to b

Behaviour:
- Reset: state IDLE. busy, done, lat_err, bf_in_valid and mem_wr_en are 0. bf_tw_idx and bf_stage are 0. All internal counters and address delay lines are cleared. Reset mid-run aborts immediately; RAM contents are then undefined.
- FSM: IDLE -> RUN on start. RUN -> DRAIN after the stage's 32nd read issue. DRAIN -> RUN (next stage) or DONE after stage 5. DONE -> RUN on start; otherwise it stays in DONE.
- IDLE/DONE host mux: mem_wr_en=host_wr_en, mem_wr_addr=host_addr, mem_rd_addr=host_addr, mem_wr_din=host_din. Host read data appears the cycle after the address is presented.
- RUN/DRAIN: host inputs are ignored. start while busy is ignored.
- Slots: a 3-cycle slot with phase p=0,1,2 runs continuously from the first RUN cycle.
  - p0 (RUN, c<32): mem_wr_addr=a, mem_rd_addr=b, mem_wr_en=0.
  - p1: bf_in_valid=1, with bf_a/bf_b from the RAM outputs and bf_tw_idx/bf_stage of that butterfly.
  - Result writes: at p1 of slot k+BF_LAT/3, write mem_wr_addr=a_k with din=bf_x, and capture bf_y. At p2 of the same slot, write b_k with the captured y.
  - A pending (a,b) pair is held in a delay line of depth BF_LAT/3+1.
- Address generation, stage s, butterfly c=0..31: half=32>>s; a=(c/half)*2*half+(c%half); b=a+half; tw=(c%half)<<s.
- Stage timing: each stage is 96+BF_LAT cycles. DRAIN lasts until the final b-write of the stage; the next stage's first p0 is the following cycle. No read overlaps a pending write.
- Completion: done pulses and busy drops in the cycle after the final write of stage 5. Total run = 6*(96+BF_LAT) cycles, counted from the first RUN cycle, which is the cycle after start is sampled.
- lat_err: set if bf_out_valid differs from the expected pattern (1 exactly at each expected p1) in any RUN/DRAIN cycle. Writes happen on schedule regardless. lat_err is cleared when start is accepted.
- Writes never collide with reads: p0 is read-only, p1/p2 are write-only.

Test Plan:
- Reset values: assert rst mid-cycle -> busy=0, done=0, lat_err=0, mem_wr_en=0 asynchronously, and the FSM is in IDLE.
- Host load/readback: host write addr 5 = 0x2ABCD, then present addr 5 -> host_dout=0x2ABCD one cycle later. With busy=1, a host write to addr 5 -> RAM is unchanged.
- Address sequence, BF_LAT=3: stage0 c0 -> (0,32), tw0. Stage1 c16 -> (32,48), tw0. Stage1 c1 -> (1,17), tw2. Stage5 c0 -> (0,1), tw0. Stage5 c31 -> (62,63), tw0.
- Functional check with bf_x=a+1, bf_y=b+1, BF_LAT=3, RAM init ram[i]=i -> every ram[i]=i+6 at the end; done exactly 594 cycles after the first RUN cycle; lat_err=0.
- Latency variant: BF_LAT=6 with the same increment butterfly -> ram[i]=i+6; done after 612 cycles.
- Error/abort: suppress one bf_out_valid -> lat_err=1 and it stays set until the next start. Assert rst at run cycle 200 -> busy=0 at once, then host access works and a new start completes normally.
